// File: rtl/cacheline_mem_arbiter.sv
// Shares one cacheline-adapter port between the icache and dcache paths.
// One owner at a time; address and data are muxed live, never latched.
module cacheline_mem_arbiter #(
    parameter int POLICY       = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_read,
    input  logic [31:0]      i_addr,
    output logic [255:0]     i_rdata,
    output logic             i_resp,
    input  logic             d_read,
    input  logic             d_write,
    input  logic [31:0]      d_addr,
    input  logic [255:0]     d_wdata,
    output logic [255:0]     d_rdata,
    output logic             d_resp,
    output logic             a_read,
    output logic             a_write,
    output logic [31:0]      a_addr,
    output logic [255:0]     a_wdata,
    input  logic [255:0]     a_rdata,
    input  logic             a_resp,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    localparam logic       SIDE_I     = 1'b0;
    localparam logic       SIDE_D     = 1'b1;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic       last_grant;
    logic [3:0] starve_cnt;
    logic       i_req, d_req;
    logic       grant_i, grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Grant decision; only acted on while IDLE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && !d_req) begin
            grant_i = 1'b1;
        end else if (d_req && !i_req) begin
            grant_d = 1'b1;
        end else if (i_req && d_req) begin
            if (POLICY == 0) begin
                grant_i = (last_grant == SIDE_D);
                grant_d = (last_grant == SIDE_I);
            end else begin
                grant_i = (starve_cnt == STARVE_MAX);
                grant_d = (starve_cnt != STARVE_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = SERVE_I;
                end else if (grant_d) begin
                    state_nxt = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (a_resp) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fairness bookkeeping and grant counters move only on IDLE -> SERVE_x.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant  <= SIDE_D;
            starve_cnt  <= 4'd0;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_i) begin
                last_grant  <= SIDE_I;
                starve_cnt  <= 4'd0;
                i_grant_cnt <= i_grant_cnt + CNT_W'(1);
            end else if (grant_d) begin
                last_grant  <= SIDE_D;
                d_grant_cnt <= d_grant_cnt + CNT_W'(1);
                if (i_req && starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        a_read  = 1'b0;
        a_write = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        i_resp  = 1'b0;
        i_rdata = '0;
        d_resp  = 1'b0;
        d_rdata = '0;
        unique case (state)
            SERVE_I: begin
                a_read = 1'b1;
                a_addr = i_addr;
                if (a_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = a_rdata;
                end
            end
            SERVE_D: begin
                // A simultaneous read is dropped in favour of the writeback.
                a_read  = d_read & ~d_write;
                a_write = d_write;
                a_addr  = d_addr;
                a_wdata = d_wdata;
                if (a_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = a_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: a POLICY 0 and a POLICY 1 (limit 2) instance
// driven by the same requesters, each with its own adapter and reference model.
module tb_cacheline_mem_arbiter;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_read, d_read, d_write, inj;
    logic [31:0] i_addr, d_addr;
    logic [255:0] d_wdata, pat;
    int          lat;

    logic [255:0] i_rdata [N];
    logic [255:0] d_rdata [N];
    logic [255:0] a_wdata [N];
    logic         i_resp  [N];
    logic         d_resp  [N];
    logic         a_read  [N];
    logic         a_write [N];
    logic [31:0]  a_addr  [N];
    logic [31:0]  icnt    [N];
    logic [31:0]  dcnt    [N];

    logic ad_resp [N];
    int   ad_cnt  [N];

    // Reference model: owner 0 = nobody, 1 = icache, 2 = dcache.
    int          m_own    [N];
    logic        m_rel    [N];
    logic        m_lastd  [N];
    int          m_starve [N];
    logic [31:0] m_ic     [N];
    logic [31:0] m_dc     [N];

    string gs [N];
    int    total = 0;
    int    bad   = 0;

    localparam logic [255:0] P1 = {8{32'hDEADBEEF}};
    localparam logic [255:0] P2 = {8{32'h01234567}};
    localparam logic [255:0] P3 = {4{64'hCAFEF00D_5A5A1234}};
    localparam logic [255:0] PA5 = {32{8'hA5}};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        cacheline_mem_arbiter #(
            .POLICY(g),
            .STARVE_LIMIT(g == 0 ? 4 : 2),
            .CNT_W(32)
        ) dut (
            .clk(clk), .rst(rst),
            .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata[g]), .i_resp(i_resp[g]),
            .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_rdata(d_rdata[g]), .d_resp(d_resp[g]),
            .a_read(a_read[g]), .a_write(a_write[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
            .a_rdata(pat), .a_resp(ad_resp[g] | inj),
            .i_grant_cnt(icnt[g]), .d_grant_cnt(dcnt[g])
        );
    end

    // Adapter: answers `lat` cycles after a transfer starts, reset with the arbiter.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < N; k++) begin
            if (!rst) begin
                ad_resp[k] <= 1'b0;
                ad_cnt[k]  <= 0;
            end else if (ad_resp[k]) begin
                ad_resp[k] <= 1'b0;
                ad_cnt[k]  <= 0;
            end else if (a_read[k] || a_write[k]) begin
                ad_cnt[k] <= ad_cnt[k] + 1;
                if (ad_cnt[k] + 1 >= lat) ad_resp[k] <= 1'b1;
            end else begin
                ad_cnt[k] <= 0;
            end
        end
    end

    function automatic int pick(int k, logic ir, logic dr);
        if (ir && dr) begin
            if (k == 0) return m_lastd[k] ? 1 : 2;
            return (m_starve[k] >= 2) ? 1 : 2;
        end
        if (ir) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < N; k++) begin
            if (!rst) begin
                m_own[k] <= 0; m_rel[k] <= 1'b0; m_lastd[k] <= 1'b1;
                m_starve[k] <= 0; m_ic[k] <= 32'd0; m_dc[k] <= 32'd0;
            end else if (m_own[k] != 0) begin
                if (ad_resp[k] | inj) begin
                    m_own[k] <= 0;
                    m_rel[k] <= 1'b1;
                end
            end else if (m_rel[k]) begin
                m_rel[k] <= 1'b0;
            end else if (pick(k, i_read, d_read | d_write) == 1) begin
                m_own[k] <= 1; m_lastd[k] <= 1'b0; m_starve[k] <= 0;
                m_ic[k] <= m_ic[k] + 32'd1;
            end else if (pick(k, i_read, d_read | d_write) == 2) begin
                m_own[k] <= 2; m_lastd[k] <= 1'b1;
                m_dc[k] <= m_dc[k] + 32'd1;
                if (i_read && m_starve[k] < (k == 0 ? 4 : 2)) m_starve[k] <= m_starve[k] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, k, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input int k, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%s want=%s", nm, k, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string nm);
        int c = 0;
        @(negedge clk);
        while (!(i_resp[0] || d_resp[0]) && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (c >= 60) begin
            total++;
            bad++;
            $display("FAIL %s timeout got=no_resp want=resp", nm);
        end
    endtask

    task automatic drop();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    logic finished = 1'b0;
    int   mark [N];

    initial begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; inj = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pat = P1; lat = 2;
        fork
            begin : compare_loop
                forever begin
                    @(negedge clk);
                    for (int k = 0; k < N; k++) begin
                        chk("a_read", k, 256'(a_read[k]),
                            256'((m_own[k] == 1) || (m_own[k] == 2 && d_read && !d_write)));
                        chk("a_write", k, 256'(a_write[k]), 256'(m_own[k] == 2 && d_write));
                        chk("a_addr", k, 256'(a_addr[k]),
                            256'(m_own[k] == 1 ? i_addr : (m_own[k] == 2 ? d_addr : 32'h0)));
                        chk("a_wdata", k, a_wdata[k], m_own[k] == 2 ? d_wdata : 256'h0);
                        chk("i_resp", k, 256'(i_resp[k]), 256'(m_own[k] == 1 && (ad_resp[k] | inj)));
                        chk("i_rdata", k, i_rdata[k],
                            (m_own[k] == 1 && (ad_resp[k] | inj)) ? pat : 256'h0);
                        chk("d_resp", k, 256'(d_resp[k]), 256'(m_own[k] == 2 && (ad_resp[k] | inj)));
                        chk("d_rdata", k, d_rdata[k],
                            (m_own[k] == 2 && (ad_resp[k] | inj)) ? pat : 256'h0);
                        chk("i_grant_cnt", k, 256'(icnt[k]), 256'(m_ic[k]));
                        chk("d_grant_cnt", k, 256'(dcnt[k]), 256'(m_dc[k]));
                        if (i_resp[k]) gs[k] = {gs[k], "I"};
                        if (d_resp[k]) gs[k] = {gs[k], "D"};
                    end
                end
            end
            begin : stimulus
                // Reset held while icache requests; grant only after release.
                #1 rst = 1'b0;
                i_read = 1'b1; i_addr = 32'h0000_0100;
                step(2);
                for (int k = 0; k < N; k++) begin
                    chk("rst_a_read", k, 256'(a_read[k]), 256'(0));
                    chk("rst_a_addr", k, 256'(a_addr[k]), 256'(0));
                end
                rst = 1'b1;
                step(1);
                for (int k = 0; k < N; k++) begin
                    chk("first_a_read", k, 256'(a_read[k]), 256'(1));
                    chk("first_a_addr", k, 256'(a_addr[k]), 256'(32'h100));
                end
                wait_resp("t1");
                step(1); drop();
                for (int k = 0; k < N; k++) chk("t1_icnt", k, 256'(icnt[k]), 256'(1));

                // Single icache fill, 5-cycle adapter.
                rst = 1'b0; step(1); rst = 1'b1;
                i_addr = 32'h0000_0060; lat = 5; pat = P2; i_read = 1'b1;
                wait_resp("t2");
                for (int k = 0; k < N; k++) begin
                    chk("t2_i_resp", k, 256'(i_resp[k]), 256'(1));
                    chk("t2_i_rdata", k, i_rdata[k], P2);
                    chk("t2_d_resp", k, 256'(d_resp[k]), 256'(0));
                end
                step(1); drop();
                for (int k = 0; k < N; k++) begin
                    chk("t2_rel_i_resp", k, 256'(i_resp[k]), 256'(0));
                    chk("t2_icnt", k, 256'(icnt[k]), 256'(1));
                end

                // Stray adapter response while idle must be ignored.
                step(1); inj = 1'b1;
                @(negedge clk);
                for (int k = 0; k < N; k++) begin
                    chk("idle_inj_i_resp", k, 256'(i_resp[k]), 256'(0));
                    chk("idle_inj_d_resp", k, 256'(d_resp[k]), 256'(0));
                end
                step(1); inj = 1'b0;

                // Continuous contention.
                for (int k = 0; k < N; k++) mark[k] = gs[k].len();
                lat = 3; pat = P3; i_addr = 32'h200; d_addr = 32'h300;
                i_read = 1'b1; d_read = 1'b1;
                for (int c = 0; c < 200 && gs[0].len() < mark[0] + 8; c++) @(negedge clk);
                step(1); drop();
                step(1);
                chk_s("rr_order", 0, gs[0].substr(mark[0], mark[0] + 7), "DIDIDIDI");
                chk_s("prio_order", 1, gs[1].substr(mark[1], mark[1] + 7), "DDIDDIDD");
                chk("rr_icnt", 0, 256'(icnt[0]), 256'(5));
                chk("rr_dcnt", 0, 256'(dcnt[0]), 256'(4));
                chk("prio_icnt", 1, 256'(icnt[1]), 256'(3));
                chk("prio_dcnt", 1, 256'(dcnt[1]), 256'(6));

                // Dcache fill, writeback, and write+read together.
                lat = 2; d_read = 1'b1; d_addr = 32'h2000;
                step(1);
                chk("dr_a_read", 0, 256'(a_read[0]), 256'(1));
                wait_resp("dr");
                chk("dr_d_rdata", 0, d_rdata[0], P3);
                chk("dr_i_resp", 0, 256'(i_resp[0]), 256'(0));
                step(1); drop(); step(1);
                d_write = 1'b1; d_addr = 32'h1000; d_wdata = PA5;
                step(1);
                for (int k = 0; k < N; k++) begin
                    chk("wb_a_write", k, 256'(a_write[k]), 256'(1));
                    chk("wb_a_read", k, 256'(a_read[k]), 256'(0));
                    chk("wb_a_addr", k, 256'(a_addr[k]), 256'(32'h1000));
                    chk("wb_a_wdata", k, a_wdata[k], PA5);
                end
                wait_resp("wb");
                chk("wb_d_resp", 0, 256'(d_resp[0]), 256'(1));
                chk("wb_i_resp", 0, 256'(i_resp[0]), 256'(0));
                step(1); drop(); step(1);
                d_write = 1'b1; d_read = 1'b1; d_addr = 32'h1020;
                step(1);
                chk("rw_a_write", 0, 256'(a_write[0]), 256'(1));
                chk("rw_a_read", 0, 256'(a_read[0]), 256'(0));
                wait_resp("rw");
                step(1); drop(); step(1);
                chk("d_total", 0, 256'(dcnt[0]), 256'(7));
                chk("d_total", 1, 256'(dcnt[1]), 256'(9));

                // Asynchronous reset in the middle of a writeback.
                lat = 10; d_write = 1'b1; d_addr = 32'h1040;
                step(3);
                @(negedge clk); #2 rst = 1'b0; #1;
                for (int k = 0; k < N; k++) begin
                    chk("mid_rst_a_write", k, 256'(a_write[k]), 256'(0));
                    chk("mid_rst_dcnt", k, 256'(dcnt[k]), 256'(0));
                end
                step(1); rst = 1'b1;
                step(1);
                for (int k = 0; k < N; k++) begin
                    chk("restart_a_write", k, 256'(a_write[k]), 256'(1));
                    chk("restart_dcnt", k, 256'(dcnt[k]), 256'(1));
                end
                wait_resp("restart");
                chk("restart_d_resp", 0, 256'(d_resp[0]), 256'(1));
                step(1); drop(); step(2);
                chk("end_icnt", 0, 256'(icnt[0]), 256'(0));
                finished = 1'b1;
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
